regfile_writeback_queue: RTL

- Writer-side front end for the 32x32 register file: buffers writeback requests from the execute/memory stages and drives the file's write port (write/Daddress/Ddata), one write per cycle.
- Provides two bypass lookup ports so the decode stage sees values still pending in the queue. Decode reads the register file directly and muxes in bypass data on a hit.
- Sits between the pipeline writeback logic and the register file.

---
 rtl/regfile_writeback_queue.sv | 90 +++++++++
 1 files changed

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - writeback FIFO in front of the register file write port
// Queue entries plus the registered output stage form the pending-write set seen by bypass lookups.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [4:0]    req_addr,
  input  logic [31:0]   req_data,
  input  logic          drain_en,
  output logic          rf_write,
  output logic [4:0]    rf_daddr,
  output logic [31:0]   rf_ddata,
  input  logic [4:0]    a_addr,
  output logic          a_hit,
  output logic [31:0]   a_data,
  input  logic [4:0]    b_addr,
  output logic          b_hit,
  output logic [31:0]   b_data,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [4:0]    q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop;

  assign req_ready = (count != CW'(DEPTH));
  // Writes to r0 are accepted but dropped, since that register is hardwired zero.
  assign push      = req_valid && req_ready && (req_addr != 5'd0);
  assign pop       = drain_en && (count != '0);
  assign empty     = (count == '0) && !rf_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      rf_write <= 1'b0;
      rf_daddr <= '0;
      rf_ddata <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count    <= count + CW'(push) - CW'(pop);
      rf_write <= pop;
      if (pop) begin
        rf_daddr <= q_addr[head];
        rf_ddata <= q_data[head];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= req_addr;
      q_data[tail] <= req_data;
    end
  end

  // Scan oldest to youngest so the youngest match overrides; output stage is oldest of all.
  function automatic logic [32:0] lookup(input logic [4:0] a);
    logic [32:0]   r;
    logic [PW-1:0] idx;
    r = '0;
    if (a != 5'd0) begin
      if (rf_write && (rf_daddr == a)) r = {1'b1, rf_ddata};
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if ((CW'(i) < count) && (q_addr[idx] == a)) r = {1'b1, q_data[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {a_hit, a_data} = lookup(a_addr);
  end

  always_comb begin
    {b_hit, b_data} = lookup(b_addr);
  end
endmodule
